hazard_ctrl: RTL and testbench

HAZARD_CTRL -- requirements
Module: hazard_ctrl

---
 rtl/hazard_ctrl.sv | 165 ++++++++++++++++
 tb/tb_hazard_ctrl.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : hazard_ctrl
// Description : Pipeline hazard controller for the register stage.
//               Tracks the func- and data-stage occupants in shadow registers,
//               selects operand forwarding sources, detects load-use hazards
//               (one-cycle stall plus a func bubble), and sequences multi-cycle
//               FPU operations through a RUN / FPU_BUSY state machine.
//               Also counts stalled cycles with saturation.
// Ports       : clk, rst (async, active-low)
//               issue_*      register-stage instruction description
//               stall_front  hold pc and inst->reg
//               hold_func    hold reg->func
//               bubble_func  NOP into reg->func
//               bubble_data  NOP into func->data
//               fwd_a_sel / fwd_b_sel  00 regfile, 01 func result, 10 data result
//               fpu_busy     multi-cycle FPU op occupies func
//               stall_cycles saturating count of stall_front cycles
// Revision    : 1.0  initial release
// ============================================================================
module hazard_ctrl #(
    parameter int FPU_LAT = 3
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        issue_valid,
    input  logic        issue_rs_a_en,
    input  logic        issue_rs_b_en,
    input  logic [4:0]  issue_rs_a_addr,
    input  logic [4:0]  issue_rs_b_addr,
    input  logic        issue_rd_en,
    input  logic [4:0]  issue_rd_addr,
    input  logic        issue_is_load,
    input  logic        issue_use_fpu,
    output logic        stall_front,
    output logic        hold_func,
    output logic        bubble_func,
    output logic        bubble_data,
    output logic [1:0]  fwd_a_sel,
    output logic [1:0]  fwd_b_sel,
    output logic        fpu_busy,
    output logic [15:0] stall_cycles
);

    localparam logic [0:0] c_ST_RUN      = 1'b0;
    localparam logic [0:0] c_ST_FPU_BUSY = 1'b1;
    // Busy cycles after the issuing cycle; the op spends one cycle in func
    // as it advances, so FPU_LAT-1 further cycles remain.
    localparam logic [3:0] c_CNT_LOAD    = 4'(FPU_LAT - 1);
    localparam logic       c_FPU_MULTI   = (FPU_LAT > 1);
    localparam logic [15:0] c_SAT        = 16'hFFFF;

    logic [0:0]  r_state;
    logic [3:0]  r_cnt;

    // Func-stage occupant shadow
    logic        r_f_valid;
    logic        r_f_rd_en;
    logic [4:0]  r_f_rd_addr;
    logic        r_f_is_load;

    // Data-stage occupant shadow
    logic        r_d_valid;
    logic        r_d_rd_en;
    logic [4:0]  r_d_rd_addr;

    logic [15:0] r_stall_cycles;

    logic        w_busy;
    logic        w_fa_hit;
    logic        w_fb_hit;
    logic        w_da_hit;
    logic        w_db_hit;
    logic        w_load_use;
    logic        w_stall;
    logic        w_fpu_start;

    assign w_busy = (r_state == c_ST_FPU_BUSY);

    // Register 0 is an ordinary register here, so no zero-address exclusion.
    assign w_fa_hit = issue_valid & issue_rs_a_en & r_f_valid & r_f_rd_en &
                      (issue_rs_a_addr == r_f_rd_addr);
    assign w_fb_hit = issue_valid & issue_rs_b_en & r_f_valid & r_f_rd_en &
                      (issue_rs_b_addr == r_f_rd_addr);
    assign w_da_hit = issue_valid & issue_rs_a_en & r_d_valid & r_d_rd_en &
                      (issue_rs_a_addr == r_d_rd_addr);
    assign w_db_hit = issue_valid & issue_rs_b_en & r_d_valid & r_d_rd_en &
                      (issue_rs_b_addr == r_d_rd_addr);

    // A load's data is not ready in func; the consumer waits one cycle and
    // then picks the value up from the data stage. While the FPU holds the
    // pipe the check is meaningless and is redone on the first RUN cycle.
    assign w_load_use  = ~w_busy & r_f_is_load & (w_fa_hit | w_fb_hit);
    assign w_stall     = w_busy | w_load_use;
    assign w_fpu_start = issue_valid & issue_use_fpu & ~w_load_use & c_FPU_MULTI;

    // Func result is only forwardable when it is not a pending load; in that
    // case an older data-stage match is still a valid source.
    always_comb begin
        fwd_a_sel = 2'b00;
        if (w_fa_hit && !r_f_is_load) begin
            fwd_a_sel = 2'b01;
        end else if (w_da_hit) begin
            fwd_a_sel = 2'b10;
        end
    end

    always_comb begin
        fwd_b_sel = 2'b00;
        if (w_fb_hit && !r_f_is_load) begin
            fwd_b_sel = 2'b01;
        end else if (w_db_hit) begin
            fwd_b_sel = 2'b10;
        end
    end

    assign stall_front  = w_stall;
    assign bubble_func  = w_load_use;
    assign hold_func    = w_busy;
    assign bubble_data  = w_busy;
    assign fpu_busy     = w_busy;
    assign stall_cycles = r_stall_cycles;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state        <= c_ST_RUN;
            r_cnt          <= 4'd0;
            r_f_valid      <= 1'b0;
            r_f_rd_en      <= 1'b0;
            r_f_rd_addr    <= 5'd0;
            r_f_is_load    <= 1'b0;
            r_d_valid      <= 1'b0;
            r_d_rd_en      <= 1'b0;
            r_d_rd_addr    <= 5'd0;
            r_stall_cycles <= 16'd0;
        end else begin
            if (r_state == c_ST_RUN) begin
                r_f_valid   <= issue_valid & ~w_load_use;
                r_f_rd_en   <= issue_rd_en;
                r_f_rd_addr <= issue_rd_addr;
                r_f_is_load <= issue_is_load;
                r_d_valid   <= r_f_valid;
                r_d_rd_en   <= r_f_rd_en;
                r_d_rd_addr <= r_f_rd_addr;
                if (w_fpu_start) begin
                    r_state <= c_ST_FPU_BUSY;
                    r_cnt   <= c_CNT_LOAD;
                end
            end else begin
                // Func occupant stays put; nothing new reaches data.
                r_d_valid <= 1'b0;
                r_cnt     <= r_cnt - 4'd1;
                if (r_cnt == 4'd1) begin
                    r_state <= c_ST_RUN;
                end
            end

            if (w_stall && (r_stall_cycles != c_SAT)) begin
                r_stall_cycles <= r_stall_cycles + 16'd1;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_hazard_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_hazard_ctrl
// Description : Self-checking bench for hazard_ctrl. Two instances
//               (FPU_LAT=3 and FPU_LAT=15) share stimulus; a behavioural
//               pipeline model predicts every output each cycle, and
//               directed scenarios pin the model with literal expectations.
// Revision    : 1.0  initial release
// ============================================================================
module tb_hazard_ctrl;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic       rst;
    logic       issue_valid;
    logic       issue_rs_a_en;
    logic       issue_rs_b_en;
    logic [4:0] issue_rs_a_addr;
    logic [4:0] issue_rs_b_addr;
    logic       issue_rd_en;
    logic [4:0] issue_rd_addr;
    logic       issue_is_load;
    logic       issue_use_fpu;

    logic        sf[2];
    logic        hf[2];
    logic        bf[2];
    logic        bd[2];
    logic [1:0]  fa[2];
    logic [1:0]  fb[2];
    logic        fbz[2];
    logic [15:0] sc[2];

    hazard_ctrl #(.FPU_LAT(3)) u_dut3 (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid),
        .issue_rs_a_en(issue_rs_a_en), .issue_rs_b_en(issue_rs_b_en),
        .issue_rs_a_addr(issue_rs_a_addr), .issue_rs_b_addr(issue_rs_b_addr),
        .issue_rd_en(issue_rd_en), .issue_rd_addr(issue_rd_addr),
        .issue_is_load(issue_is_load), .issue_use_fpu(issue_use_fpu),
        .stall_front(sf[0]), .hold_func(hf[0]), .bubble_func(bf[0]),
        .bubble_data(bd[0]), .fwd_a_sel(fa[0]), .fwd_b_sel(fb[0]),
        .fpu_busy(fbz[0]), .stall_cycles(sc[0])
    );

    hazard_ctrl #(.FPU_LAT(15)) u_dut15 (
        .clk(clk), .rst(rst),
        .issue_valid(issue_valid),
        .issue_rs_a_en(issue_rs_a_en), .issue_rs_b_en(issue_rs_b_en),
        .issue_rs_a_addr(issue_rs_a_addr), .issue_rs_b_addr(issue_rs_b_addr),
        .issue_rd_en(issue_rd_en), .issue_rd_addr(issue_rd_addr),
        .issue_is_load(issue_is_load), .issue_use_fpu(issue_use_fpu),
        .stall_front(sf[1]), .hold_func(hf[1]), .bubble_func(bf[1]),
        .bubble_data(bd[1]), .fwd_a_sel(fa[1]), .fwd_b_sel(fb[1]),
        .fpu_busy(fbz[1]), .stall_cycles(sc[1])
    );

    typedef struct {
        bit v;
        bit aen;
        int a;
        bit ben;
        int b;
        bit rden;
        int rd;
        bit ld;
        bit fpu;
    } stim_t;

    typedef struct {
        bit valid;
        bit rd_en;
        int rd;
        bit is_load;
    } occ_t;

    // Model: which instruction sits in func / data, and how many more
    // cycles the FPU keeps the pipe frozen.
    occ_t  m_f[2];
    occ_t  m_d[2];
    int    m_busy_left[2];
    int    m_stalls[2];
    int    lat[2];
    stim_t cur;

    int n_vec = 0;
    int n_err = 0;

    task automatic check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic bit hit(occ_t o, bit en, int addr);
        return cur.v && en && o.valid && o.rd_en && (o.rd == addr);
    endfunction

    task automatic model_eval(input int k, output bit e_busy, output bit e_lu,
                              output int e_fa, output int e_fb);
        bit fha, fhb, dha, dhb;
        fha = hit(m_f[k], cur.aen, cur.a);
        fhb = hit(m_f[k], cur.ben, cur.b);
        dha = hit(m_d[k], cur.aen, cur.a);
        dhb = hit(m_d[k], cur.ben, cur.b);
        e_busy = (m_busy_left[k] > 0);
        e_lu   = !e_busy && m_f[k].is_load && (fha || fhb);
        e_fa   = (fha && !m_f[k].is_load) ? 1 : (dha ? 2 : 0);
        e_fb   = (fhb && !m_f[k].is_load) ? 1 : (dhb ? 2 : 0);
    endtask

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_f[k] = '{valid: 0, rd_en: 0, rd: 0, is_load: 0};
            m_d[k] = '{valid: 0, rd_en: 0, rd: 0, is_load: 0};
            m_busy_left[k] = 0;
            m_stalls[k]    = 0;
        end
    endtask

    task automatic compare_all();
        bit e_busy, e_lu;
        int e_fa, e_fb;
        for (int k = 0; k < 2; k++) begin
            string s;
            s = $sformatf("lat%0d", lat[k]);
            model_eval(k, e_busy, e_lu, e_fa, e_fb);
            check({"stall_front/", s}, int'(sf[k]),  int'(e_busy || e_lu));
            check({"hold_func/", s},   int'(hf[k]),  int'(e_busy));
            check({"bubble_func/", s}, int'(bf[k]),  int'(e_lu));
            check({"bubble_data/", s}, int'(bd[k]),  int'(e_busy));
            check({"fpu_busy/", s},    int'(fbz[k]), int'(e_busy));
            check({"fwd_a_sel/", s},   int'(fa[k]),  e_fa);
            check({"fwd_b_sel/", s},   int'(fb[k]),  e_fb);
            check({"stall_cycles/", s}, int'(sc[k]), m_stalls[k]);
        end
    endtask

    task automatic model_step();
        bit e_busy, e_lu;
        int e_fa, e_fb;
        for (int k = 0; k < 2; k++) begin
            model_eval(k, e_busy, e_lu, e_fa, e_fb);
            if (e_busy) begin
                m_busy_left[k]--;
                m_d[k].valid = 1'b0;
            end else begin
                m_d[k] = m_f[k];
                m_f[k].valid   = cur.v && !e_lu;
                m_f[k].rd_en   = cur.rden;
                m_f[k].rd      = cur.rd;
                m_f[k].is_load = cur.ld;
                if (cur.v && cur.fpu && !e_lu && lat[k] > 1)
                    m_busy_left[k] = lat[k] - 1;
            end
            if (e_busy || e_lu)
                m_stalls[k] = (m_stalls[k] >= 65535) ? 65535 : m_stalls[k] + 1;
        end
    endtask

    // One clock cycle: apply at the falling edge, sample 1 ns later (well
    // before the rising edge), then advance the model to the next cycle.
    task automatic tick(input stim_t s, input bit rst_v);
        @(negedge clk);
        cur             = s;
        rst             = rst_v;
        issue_valid     = s.v;
        issue_rs_a_en   = s.aen;
        issue_rs_a_addr = 5'(s.a);
        issue_rs_b_en   = s.ben;
        issue_rs_b_addr = 5'(s.b);
        issue_rd_en     = s.rden;
        issue_rd_addr   = 5'(s.rd);
        issue_is_load   = s.ld;
        issue_use_fpu   = s.fpu;
        if (!rst_v) model_reset();
        #1;
        compare_all();
        if (rst_v) model_step();
    endtask

    function automatic stim_t op(bit rden, int rd, bit aen, int a, bit ben, int b,
                                 bit ld, bit fpu);
        stim_t s;
        s = '{v: 1, aen: aen, a: a, ben: ben, b: b, rden: rden, rd: rd, ld: ld, fpu: fpu};
        return s;
    endfunction

    function automatic stim_t nop();
        stim_t s;
        s = '{v: 0, aen: 0, a: 0, ben: 0, b: 0, rden: 0, rd: 0, ld: 0, fpu: 0};
        return s;
    endfunction

    function automatic stim_t rnd();
        stim_t s;
        s.v    = ($urandom % 5) != 0;
        s.aen  = $urandom % 2;
        s.a    = $urandom_range(0, 3);
        s.ben  = $urandom % 2;
        s.b    = $urandom_range(0, 3);
        s.rden = ($urandom % 4) != 0;
        s.rd   = $urandom_range(0, 3);
        s.ld   = ($urandom % 4) == 0;
        s.fpu  = ($urandom % 6) == 0;
        return s;
    endfunction

    initial begin
        lat[0] = 3;
        lat[1] = 15;
        model_reset();
        cur = nop();
        rst = 1'b0;
        issue_valid = 0; issue_rs_a_en = 0; issue_rs_b_en = 0;
        issue_rs_a_addr = 0; issue_rs_b_addr = 0; issue_rd_en = 0;
        issue_rd_addr = 0; issue_is_load = 0; issue_use_fpu = 0;

        // Reset: a valid reader still gets regfile and no stall.
        tick(op(1, 2, 1, 2, 1, 2, 0, 0), 1'b0);
        tick(op(1, 2, 1, 2, 1, 2, 0, 0), 1'b0);
        check("rst_stall_front", int'(sf[0]), 0);
        check("rst_fwd_a", int'(fa[0]), 0);
        check("rst_stall_cycles", int'(sc[0]), 0);

        // Load r3 then consumer of r3 on B: one bubble, then data forward.
        tick(op(1, 3, 0, 0, 0, 0, 1, 0), 1'b1);
        tick(op(1, 10, 0, 0, 1, 3, 0, 0), 1'b1);
        check("lu_stall_front", int'(sf[0]), 1);
        check("lu_bubble_func", int'(bf[0]), 1);
        tick(op(1, 10, 0, 0, 1, 3, 0, 0), 1'b1);
        check("lu_after_stall", int'(sf[0]), 0);
        check("lu_fwd_b", int'(fb[0]), 2);
        check("lu_stall_cycles", int'(sc[0]), 1);

        // Back-to-back ALU on r5.
        tick(op(1, 5, 0, 0, 0, 0, 0, 0), 1'b1);
        tick(op(1, 9, 1, 5, 0, 0, 0, 0), 1'b1);
        check("alu_fwd_a_func", int'(fa[0]), 1);
        check("alu_no_stall", int'(sf[0]), 0);
        tick(op(1, 11, 1, 5, 0, 0, 0, 0), 1'b1);
        check("alu_fwd_a_data", int'(fa[0]), 2);

        // r7 in both func and data: func wins.
        tick(op(1, 7, 0, 0, 0, 0, 0, 0), 1'b1);
        tick(op(1, 7, 0, 0, 0, 0, 0, 0), 1'b1);
        tick(op(1, 12, 1, 7, 0, 0, 0, 0), 1'b1);
        check("prio_fwd_a", int'(fa[0]), 1);

        // FPU op, latency 3: exactly two frozen cycles.
        tick(op(1, 13, 0, 0, 0, 0, 0, 1), 1'b1);
        check("fpu_issue_busy", int'(fbz[0]), 0);
        for (int i = 0; i < 2; i++) begin
            tick(nop(), 1'b1);
            check("fpu_busy", int'(fbz[0]), 1);
            check("fpu_stall", int'(sf[0]), 1);
            check("fpu_hold", int'(hf[0]), 1);
            check("fpu_bubble_data", int'(bd[0]), 1);
        end
        tick(nop(), 1'b1);
        check("fpu_done_busy", int'(fbz[0]), 0);
        check("fpu_done_stall", int'(sf[0]), 0);

        // Reset in the middle of an FPU sequence.
        tick(op(1, 14, 0, 0, 0, 0, 0, 1), 1'b1);
        tick(nop(), 1'b1);
        check("abort_pre_busy", int'(fbz[0]), 1);
        tick(nop(), 1'b0);
        check("abort_busy", int'(fbz[0]), 0);
        check("abort_stall", int'(sf[0]), 0);
        check("abort_hold", int'(hf[0]), 0);
        check("abort_cycles", int'(sc[0]), 0);
        tick(nop(), 1'b1);
        check("abort_release_stall", int'(sf[0]), 0);
        check("abort_release_cycles", int'(sc[0]), 0);

        // Random traffic with occasional asynchronous resets.
        for (int i = 0; i < 3000; i++) begin
            tick(rnd(), ($urandom % 300) != 0);
        end

        // Saturation: a load+FPU op reading its own destination each cycle
        // keeps the FPU_LAT=15 instance stalled 15 of every 16 cycles.
        tick(nop(), 1'b0);
        for (int i = 0; i < 70200; i++) begin
            tick(op(1, 1, 1, 1, 0, 0, 1, 1), 1'b1);
        end
        check("sat_stall_cycles", int'(sc[1]), 16'hFFFF);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
